// File: rtl/row_accumulator.sv
// ---------------------------------------------------------------------------
// row_accumulator
//
// Dot-product stage fed by the column index counter. Every accepted beat
// multiplies a signed weight by a signed activation and accumulates the
// product. Column 0 starts a fresh sum. The beat flagged with will_reset
// closes the row. The finished sum moves into a one-entry output buffer,
// tagged with its row index, and is offered downstream with valid/ready.
//
// Optional feature (compile-time macro):
//   ROW_ACCUMULATOR_RELU_EN - when defined, a negative row sum is stored
//                             into the output buffer as 0. The running
//                             accumulator is not affected.
//
// Parameters:
//   DATA_WIDTH - width of the signed weight and activation operands
//   ACC_WIDTH  - signed accumulator / result width (>= 2*DATA_WIDTH+2)
//   NUM_ROWS   - rows per matrix; the row index wraps after NUM_ROWS-1
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous clear of all state, highest priority
//   in_valid     in   weight/activation beat present
//   in_ready     out  block can accept a beat
//   weight       in   signed weight
//   activation   in   signed activation
//   column_index in   current column from the column counter
//   will_reset   in   current beat is the last column of the row
//   col_en       out  column counter enable (accepted beat)
//   col_clear    out  column counter clear (mirrors clear)
//   out_valid    out  row result held in the output buffer
//   out_ready    in   downstream accepts the result
//   out_data     out  signed row sum
//   out_row      out  row index of out_data
//   done         out  pulse when the result for row NUM_ROWS-1 is taken
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. A valid source holds its payload stable
// until that edge; ready may change freely and carries no promise on its
// own. Here in_ready depends only on the output buffer state and
// out_ready, never on the input payload.
//
// The output buffer is a two-state machine (EMPTY/FULL). Its state register
// is driven straight onto out_valid, so the state is always observable at
// the port.
// ---------------------------------------------------------------------------
module row_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int NUM_ROWS   = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0] activation,
  input  logic [1:0]                   column_index,
  input  logic                         will_reset,
  output logic                         col_en,
  output logic                         col_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic [1:0]                   out_row,
  output logic                         done
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

  // Output buffer states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [0:0]                  state_q,    state_d;
  logic signed [ACC_WIDTH-1:0] acc_q,      acc_d;
  logic [1:0]                  row_q,      row_d;
  logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]                  out_row_q,  out_row_d;

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  row_sum;
  logic signed [ACC_WIDTH-1:0]  store_val;
  logic                         accept;
  logic                         last_accept;
  logic                         out_fire;
  logic [1:0]                   row_inc;

  // Full-precision signed product, sign-extended into the accumulator width.
  assign prod     = weight * activation;
  assign prod_ext = {{EXT_WIDTH{prod[PROD_WIDTH-1]}}, prod};

  // Column 0 starts a new sum; any other column extends the running one.
  // The add wraps modulo 2^ACC_WIDTH by construction.
  assign row_sum = (column_index == 2'd0) ? prod_ext : (acc_q + prod_ext);

`ifdef ROW_ACCUMULATOR_RELU_EN
  assign store_val = row_sum[ACC_WIDTH-1] ? '0 : row_sum;
`else
  assign store_val = row_sum;
`endif

  // ------------------------------------------------------------------
  // Handshake and counter control
  // ------------------------------------------------------------------
  assign out_valid   = (state_q == ST_FULL);
  // A stalled full buffer blocks every beat, not only the last column,
  // so the column counter freezes together with the accumulator.
  assign in_ready    = ~(out_valid & ~out_ready);
  assign accept      = in_valid & in_ready & ~clear;
  assign last_accept = accept & will_reset;
  assign out_fire    = out_valid & out_ready;

  assign col_en      = accept;
  assign col_clear   = clear;

  assign done        = out_fire & (out_row_q == LAST_ROW);

  assign out_data    = out_data_q;
  assign out_row     = out_row_q;

  assign row_inc     = (row_q == LAST_ROW) ? 2'd0 : (row_q + 2'd1);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    row_d      = row_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;

    if (clear) begin
      // Any beat presented with clear is dropped, and so is a buffered row.
      state_d    = ST_EMPTY;
      acc_d      = '0;
      row_d      = 2'd0;
      out_data_d = '0;
      out_row_d  = 2'd0;
    end else begin
      if (accept) begin
        acc_d = row_sum;
      end

      if (last_accept) begin
        out_data_d = store_val;
        out_row_d  = row_q;
        row_d      = row_inc;
      end

      case (state_q)
        ST_EMPTY: begin
          if (last_accept) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          // A last-column accept can only happen here when out_ready is
          // high, so the old result leaves as the new one loads.
          if (last_accept) begin
            state_d = ST_FULL;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      acc_q      <= '0;
      row_q      <= 2'd0;
      out_data_q <= '0;
      out_row_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      out_data_q <= out_data_d;
      out_row_q  <= out_row_d;
    end
  end

endmodule

// File: doc/row_accumulator.md
# row_accumulator

Dot-product stage that sits directly downstream of the column index counter in the neural-net datapath. Each accepted beat multiplies one signed weight by one signed activation and accumulates the product. The column counter's `column_index` and `will_reset` mark the first and last column of each row. When a row completes, the sum is registered into a one-entry output buffer and offered downstream with a valid/ready handshake, tagged with its row index.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of signed weight and activation operands.
- `ACC_WIDTH`, 20: signed accumulator and output width; must be ≥ 2*`DATA_WIDTH`+2.
- `NUM_ROWS`, 3: rows per matrix; the row index wraps after `NUM_ROWS`-1.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of all state; takes priority over every other input.
- `in_valid`  in  1  weight/activation beat present.
- `in_ready`  out  1  block can accept a beat.
- `weight`  in  `DATA_WIDTH`  signed weight.
- `activation`  in  `DATA_WIDTH`  signed activation.
- `column_index`  in  2  current column from the column counter.
- `will_reset`  in  1  current beat is the last column of the row.
- `col_en`  out  1  counter enable; equals `in_valid & in_ready & ~clear`.
- `col_clear`  out  1  counter clear; equals `clear`.
- `out_valid`  out  1  row result held in the output buffer.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `ACC_WIDTH`  signed row sum.
- `out_row`  out  2  row index of `out_data`.
- `done`  out  1  one-cycle pulse when the result for row `NUM_ROWS`-1 is accepted.

## Operation
- A beat is accepted when `in_valid & in_ready` are both high and `clear` is low.
- Product: the full-precision signed product `weight*activation` (2*`DATA_WIDTH` bits), sign-extended to `ACC_WIDTH`.
- Accumulator update on an accepted beat:
  - If `column_index`==0, the accumulator loads the product.
  - Otherwise it adds the product to the current value.
  - Addition wraps modulo 2^`ACC_WIDTH`; there is no saturation.
- On an accepted beat with `will_reset`=1:
  - The final sum (accumulator plus this beat's product, or the product alone if `column_index`==0) loads `out_data`.
  - The current row counter value loads `out_row`.
  - `out_valid` sets.
  - The row counter increments, wrapping from `NUM_ROWS`-1 to 0.
- Output buffer states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
  - EMPTY→FULL on a last-column accept.
  - FULL→EMPTY on `out_ready` with no new last-column accept.
  - FULL→FULL, with the new result loaded, on `out_ready` plus a last-column accept in the same cycle.
- Backpressure: `in_ready` = ~(`out_valid` & ~`out_ready`).
  - While the buffer is FULL and stalled, no beat is accepted, including non-last beats.
  - `col_en` stays low during the stall, so the counter holds.
- `done` asserts for one cycle when `out_valid & out_ready` and `out_row`==`NUM_ROWS`-1.
- `clear` zeroes the accumulator, the row counter and `out_valid`, and drives `col_clear`. A beat presented in the same cycle is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `done`=0, accumulator=0, row counter=0.
  - `in_ready` reads 1 out of reset.
  - `col_en` and `col_clear` follow their combinational inputs.
- Latency: `out_valid` rises on the clock edge that accepts the last-column beat, so it is visible in the following cycle.
- Throughput: one beat per cycle, including back-to-back rows, when `out_ready` is held high.
- Asserting `reset_n` low mid-row or mid-stall returns all state to reset values immediately. A partial row is lost.
- `in_ready`, `col_en` and `done` have no combinational path from `weight`, `activation` or `out_data`.

## Configuration
- `ROW_ACCUMULATOR_RELU_EN`:
  - Defined: a ReLU is applied when the result loads into the output buffer. A negative final sum stores as 0; non-negative sums store unchanged. The accumulator itself is unaffected.
  - Undefined: the signed sum stores as-is.

## Test plan
- Row with weights 1,2,3 and activations 4,5,6, `out_ready`=1 → `out_data`=32, `out_row`=0; `out_valid` high for exactly one cycle, the cycle after the third accept.
- Three back-to-back rows with the sums 32, -14 and 0, `out_ready`=1 → 9 consecutive accepts; outputs 32/0, -14/1, 0/2; `done` pulses with the row-2 accept. With `ROW_ACCUMULATOR_RELU_EN` defined, row 1 outputs 0.
- Hold `out_ready`=0 after row 0 completes → `in_ready`=0 and `col_en`=0. `out_data` and `out_row` stay stable for 5 cycles. Raising `out_ready` resumes accepts the same cycle.
- All operands -128, `ACC_WIDTH`=20 → row sum 49152, with no wrap.
- Assert `clear` after 2 beats of a row → `out_valid`=0, the row counter returns to 0, `col_clear`=1. The next full row produces a fresh sum tagged row 0.
- Drive `reset_n` low for half a cycle during a stall → all outputs go to reset values asynchronously and `in_ready` goes to 1.
